multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port instr, input, 32: instruction register contents from the datapath; valid from DECODE onward.
REQ-004 SHALL have port mem_ready, input, 1: memory completes the current access this cycle.
REQ-005 SHALL have port zero, input, 1: ALU zero flag; sampled in EXECUTE.
REQ-006 SHALL have port mem_req, output, 1: memory access request.
REQ-007 SHALL have port mem_we, output, 1: store request qualifier.
REQ-008 SHALL have port addr_sel, output, 1: memory address select, 0=PC, 1=ALU result.
REQ-009 SHALL have port ir_we, output, 1: IR load strobe.
REQ-010 SHALL have port pc_we, output, 1: PC write strobe.
REQ-011 SHALL have port pc_sel, output, 1: PC source select, 0=PC+4, 1=target.
REQ-012 SHALL have port rf_we, output, 1: register-file write strobe.
REQ-013 SHALL have port wb_sel, output, 2: write-back source, 0=ALU, 1=memory, 2=link PC+4.
REQ-014 SHALL have port alu_src, output, 1: ALU operand B select, 0=rs2, 1=immediate.
REQ-015 SHALL have port alu_ctrl, output, 4: ALU operation code.
REQ-016 SHALL have port state, output, 3: current FSM state, for debug.
REQ-017 SHALL have port trap, output, 1: illegal instruction seen; sticky.
REQ-018 SHALL have port retired, output, 1: one-cycle pulse per completed instruction.
REQ-019 SHALL have port retire_cnt, output, 32: count of retired instructions.

Function
REQ-020 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=7; codes 5 and 6 SHALL go to TRAP.
REQ-021 SHALL decode legal opcodes R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011 (funct3 000/001 only), JAL=1101111; anything else is illegal.
REQ-022 FETCH: mem_req=1, addr_sel=0; on mem_ready SHALL pulse ir_we=1, pc_we=1, pc_sel=0, then go to DECODE; otherwise SHALL hold FETCH with mem_req asserted.
REQ-023 DECODE: illegal -> TRAP; legal -> EXECUTE; SHALL assert no strobes.
REQ-024 EXECUTE, R/I-ALU: alu_src=(I?1:0), alu_ctrl={funct7[5] & (R or funct3==101), funct3}; next state WRITEBACK.
REQ-025 EXECUTE, LOAD/STORE: alu_src=1, alu_ctrl=0000; next state MEM.
REQ-026 EXECUTE, BRANCH: alu_src=0, alu_ctrl=1000; taken = (funct3==000 ? zero : !zero); pc_we=taken, pc_sel=1; SHALL pulse retired, then FETCH.
REQ-027 EXECUTE, JAL: pc_we=1, pc_sel=1, rf_we=1, wb_sel=2; SHALL pulse retired, then FETCH.
REQ-028 MEM: mem_req=1, addr_sel=1, mem_we=STORE; SHALL hold until mem_ready; then LOAD -> WRITEBACK, STORE -> retired pulse and FETCH.
REQ-029 WRITEBACK: rf_we=1, wb_sel=(LOAD?1:0); SHALL pulse retired, then FETCH.
REQ-030 rf_we SHALL be suppressed whenever rd (instr[11:7]) == 0.
REQ-031 mem_ready SHALL be ignored in any state other than FETCH and MEM.
REQ-032 TRAP: trap=1, all strobes 0, SHALL remain in TRAP until reset.
REQ-033 retire_cnt SHALL increment by 1 on each retired pulse and wrap from 0xFFFFFFFF to 0.
REQ-034 Control outputs SHALL be combinational from state and instr; state, trap and retire_cnt SHALL be registered.
REQ-035 Latency SHALL be (cycles with mem_ready low) plus: R/I/LOAD 4/5 cycles, STORE 4, BRANCH/JAL 3.

Reset
REQ-036 While reset=1: state=FETCH, trap=0, retire_cnt=0, and all control outputs (mem_req, mem_we, ir_we, pc_we, rf_we, retired) SHALL be forced to 0.
REQ-037 Reset asserted mid-instruction SHALL abort it without any further write strobe; the first cycle after deassertion SHALL be FETCH with mem_req=1.

Verification
REQ-038 ADD x3,x1,x2 (0x002081B3), mem_ready=1 -> states 0,1,2,4,0; rf_we once; alu_ctrl=0000; retire_cnt=1.
REQ-039 SUB (0x402081B3) -> alu_ctrl=1000; SW 0x0020A023 with mem_ready low for 3 MEM cycles -> mem_req/mem_we held for 4 cycles, no rf_we.
REQ-040 BEQ with zero=1 -> pc_we=1, pc_sel=1 in EXECUTE; BNE with zero=1 -> pc_we=0; both increment retire_cnt.
REQ-041 ADDI x0,x0,5 (0x00500013) -> rf_we never asserted; retired still pulses.
REQ-042 instr=0xFFFFFFFF -> TRAP after DECODE, trap=1 held; then reset -> trap=0, state=FETCH, retire_cnt=0.
REQ-043 Reset pulsed while in MEM with mem_req high -> mem_req drops asynchronously, no strobes, restart in FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RV32 subset core: sequences fetch, decode,
// execute, memory and write-back, and keeps a retired-instruction count.
//   state     | meaning
//   FETCH     | read instruction at PC, load IR and bump PC on mem_ready
//   DECODE    | classify opcode, illegal goes to TRAP
//   EXECUTE   | drive ALU; branch/JAL finish here
//   MEM       | load/store access, held until mem_ready
//   WRITEBACK | register-file write for ALU ops and loads
//   TRAP      | illegal instruction seen, parked until reset
module multicycle_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  state,
  output logic        trap,
  output logic        retired,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic        trap_q;
  logic [31:0] retire_cnt_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       rd_nz;
  logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_legal;

  logic mem_req_c, mem_we_c, ir_we_c, pc_we_c, rf_we_c, retired_c;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd_nz  = (instr[11:7] != 5'd0);

  assign is_r     = (opcode == 7'b0110011);
  assign is_i     = (opcode == 7'b0010011);
  assign is_ld    = (opcode == 7'b0000011);
  assign is_st    = (opcode == 7'b0100011);
  assign is_br    = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
  assign is_jal   = (opcode == 7'b1101111);
  assign is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal;

  always_comb begin
    state_d   = state_q;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    rf_we_c   = 1'b0;
    retired_c = 1'b0;
    addr_sel  = 1'b0;
    pc_sel    = 1'b0;
    wb_sel    = 2'd0;
    alu_src   = 1'b0;
    alu_ctrl  = 4'd0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = is_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (is_r || is_i) begin
          alu_src  = is_i;
          alu_ctrl = {instr[30] & (is_r | (funct3 == 3'b101)), funct3};
          state_d  = S_WRITEBACK;
        end else if (is_ld || is_st) begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (is_br) begin
          alu_ctrl  = 4'b1000;
          pc_sel    = 1'b1;
          pc_we_c   = (funct3 == 3'b000) ? zero : ~zero;
          retired_c = 1'b1;
          state_d   = S_FETCH;
        end else if (is_jal) begin
          pc_sel    = 1'b1;
          pc_we_c   = 1'b1;
          rf_we_c   = rd_nz;
          wb_sel    = 2'd2;
          retired_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          // IR changed under us after decode; treat as illegal
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        addr_sel  = 1'b1;
        mem_we_c  = is_st;
        if (mem_ready) begin
          if (is_ld) begin
            state_d = S_WRITEBACK;
          end else begin
            retired_c = 1'b1;
            state_d   = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        rf_we_c   = rd_nz;
        wb_sel    = is_ld ? 2'd1 : 2'd0;
        retired_c = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Strobes are masked by reset so nothing fires while it is held.
  assign mem_req = mem_req_c & ~reset;
  assign mem_we  = mem_we_c  & ~reset;
  assign ir_we   = ir_we_c   & ~reset;
  assign pc_we   = pc_we_c   & ~reset;
  assign rf_we   = rf_we_c   & ~reset;
  assign retired = retired_c & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      trap_q       <= 1'b0;
      retire_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_q | (state_d == S_TRAP);
      if (retired_c) retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign state      = state_q;
  assign trap       = trap_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of instructions with hand-computed
// cycle traces and strobe counts, plus trap and mid-instruction reset sequences.
module tb_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we;
  logic [1:0]  wb_sel;
  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic [2:0]  state;
  logic        trap, retired;
  logic [31:0] retire_cnt;

  multicycle_ctrl dut (
    .clock(clock), .reset(reset), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .state(state), .trap(trap),
    .retired(retired), .retire_cnt(retire_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          fwait;
    int          mwait;
    int          cyc;
    logic [47:0] trace;
    int          rf;
    int          mreq;
    int          mwe;
    logic [3:0]  alu;
    logic        xpc;
  } vec_t;

  vec_t vecs[15];
  int total = 0;
  int bad = 0;
  logic [31:0] model_cnt = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int fw, mw, cyc, rf, mreq, mwe, irw, ret;
    logic [47:0] tr;
    logic [3:0]  alu;
    logic        xpc;
    logic [2:0]  st;
    bit          done;
    v = vecs[idx];
    fw = 0; mw = 0; cyc = 0; rf = 0; mreq = 0; mwe = 0; irw = 0; ret = 0;
    tr = 48'o7; alu = 4'hF; xpc = 1'bx; done = 0;
    instr = v.ins;
    zero  = v.z;
    while (!done && cyc < 40) begin
      st = state;
      if (st == 3'd0) begin
        mem_ready = (fw >= v.fwait); fw++;
      end else if (st == 3'd3) begin
        mem_ready = (mw >= v.mwait); mw++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      cyc++;
      tr   = {tr[44:0], st};
      rf   += int'(rf_we);
      mreq += int'(mem_req);
      mwe  += int'(mem_we);
      irw  += int'(ir_we);
      if (st == 3'd2) begin
        alu = alu_ctrl;
        xpc = pc_we;
      end
      if (retired) begin
        ret++;
        done = 1;
      end
      step();
    end
    model_cnt++;
    chk($sformatf("v%0d_done", idx), done, 1);
    chk($sformatf("v%0d_cycles", idx), cyc, v.cyc);
    chk($sformatf("v%0d_trace", idx), tr, v.trace);
    chk($sformatf("v%0d_rf_we", idx), rf, v.rf);
    chk($sformatf("v%0d_mem_req", idx), mreq, v.mreq);
    chk($sformatf("v%0d_mem_we", idx), mwe, v.mwe);
    chk($sformatf("v%0d_ir_we", idx), irw, 1);
    chk($sformatf("v%0d_alu_ctrl", idx), alu, v.alu);
    chk($sformatf("v%0d_exec_pc_we", idx), xpc, v.xpc);
    chk($sformatf("v%0d_retired", idx), ret, 1);
    chk($sformatf("v%0d_retire_cnt", idx), retire_cnt, model_cnt);
    chk($sformatf("v%0d_end_state", idx), state, 0);
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_trap", trap, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_mem_req", mem_req, 0);
    step();
    reset = 1'b0;
    model_cnt = 32'd0;
    #1;
    chk("post_rst_state", state, 0);
    chk("post_rst_mem_req", mem_req, 1);
    step();
  endtask

  initial begin
    //            ins           z     fw mw cyc trace          rf mrq mwe alu   xpc
    vecs[0]  = '{32'h002081B3, 1'b0, 0, 0, 4, 48'o70124,     1, 1,  0, 4'h0, 1'b0};
    vecs[1]  = '{32'h002081B3, 1'b0, 2, 0, 6, 48'o7000124,   1, 3,  0, 4'h0, 1'b0};
    vecs[2]  = '{32'h402081B3, 1'b0, 0, 0, 4, 48'o70124,     1, 1,  0, 4'h8, 1'b0};
    vecs[3]  = '{32'h0020A023, 1'b0, 0, 3, 7, 48'o70123333,  0, 5,  4, 4'h0, 1'b0};
    vecs[4]  = '{32'h0020A223, 1'b0, 0, 0, 4, 48'o70123,     0, 2,  1, 4'h0, 1'b0};
    vecs[5]  = '{32'h0000A283, 1'b0, 0, 1, 6, 48'o7012334,   1, 3,  0, 4'h0, 1'b0};
    vecs[6]  = '{32'h00208463, 1'b1, 0, 0, 3, 48'o7012,      0, 1,  0, 4'h8, 1'b1};
    vecs[7]  = '{32'h00209463, 1'b1, 0, 0, 3, 48'o7012,      0, 1,  0, 4'h8, 1'b0};
    vecs[8]  = '{32'h00209463, 1'b0, 0, 0, 3, 48'o7012,      0, 1,  0, 4'h8, 1'b1};
    vecs[9]  = '{32'h00208463, 1'b0, 0, 0, 3, 48'o7012,      0, 1,  0, 4'h8, 1'b0};
    vecs[10] = '{32'h00500013, 1'b0, 0, 0, 4, 48'o70124,     0, 1,  0, 4'h0, 1'b0};
    vecs[11] = '{32'h4030D093, 1'b0, 0, 0, 4, 48'o70124,     1, 1,  0, 4'hD, 1'b0};
    vecs[12] = '{32'h40008093, 1'b0, 0, 0, 4, 48'o70124,     1, 1,  0, 4'h0, 1'b0};
    vecs[13] = '{32'h008000EF, 1'b0, 0, 0, 3, 48'o7012,      1, 1,  0, 4'h0, 1'b1};
    vecs[14] = '{32'h0030D093, 1'b0, 0, 0, 4, 48'o70124,     1, 1,  0, 4'h5, 1'b0};

    instr = 32'h0;
    zero  = 1'b0;
    mem_ready = 1'b0;
    reset = 1'b1;
    step();
    do_reset();

    for (int i = 0; i < 15; i++) run_vec(i);

    // Illegal opcode: trap after decode, sticky regardless of mem_ready
    instr = 32'hFFFFFFFF;
    mem_ready = 1'b1;
    step();
    chk("ill_decode", state, 1);
    step();
    chk("ill_state", state, 7);
    chk("ill_trap", trap, 1);
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0];
      #1;
      chk($sformatf("ill_hold%0d", i), {state, trap, mem_req, ir_we, pc_we, rf_we, retired},
          {3'd7, 1'b1, 5'b0});
      step();
    end
    chk("ill_cnt_kept", retire_cnt, model_cnt);
    do_reset();

    // Branch with funct3 010 is illegal
    instr = 32'h0020A063;
    mem_ready = 1'b1;
    step();
    step();
    chk("badbr_state", state, 7);
    chk("badbr_trap", trap, 1);
    do_reset();

    // Reset pulsed mid-MEM of a load
    instr = 32'h0000A283;
    mem_ready = 1'b1;
    step();
    step();
    step();
    mem_ready = 1'b0;
    #1;
    chk("mem_pre_state", state, 3);
    chk("mem_pre_req", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("mem_rst_async", {state, mem_req, mem_we, ir_we, pc_we, rf_we, retired}, 9'b0);
    step();
    chk("mem_rst_held", {state, mem_req, mem_we, ir_we, pc_we, rf_we, retired}, 9'b0);
    reset = 1'b0;
    model_cnt = 32'd0;
    #1;
    chk("mem_restart_state", state, 0);
    chk("mem_restart_req", mem_req, 1);
    chk("mem_restart_cnt", retire_cnt, 0);
    step();
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
